// File: rtl/pc_gen.sv
// pc_gen: fetch program counter generator.
// Selects the next fetch address from sequential, branch, jump, ERET and
// exception sources. A redirect that arrives while fetch is stalled is
// remembered in a pending target register until the stall drops.
// Optional feature macro: PC_ALIGN_CHECK_EN adds addrErr/badVAddr and traps
// misaligned redirect targets to EXC_VECTOR.
module pc_gen #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int          STEP         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        takeBranch,
  input  logic [31:0] branchImmEx,
  input  logic        takeJumpImm,
  input  logic [25:0] jumpImm,
  input  logic        takeJumpReg,
  input  logic [31:0] jumpReg,
  input  logic        takeException,
  input  logic        takeEret,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        redirectPending
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic        addrErr,
  output logic [31:0] badVAddr
`endif
);

  localparam logic [31:0] STEP_L = STEP;

  // Request priority codes; larger value wins. Zero means no request.
  localparam logic [2:0] PRIO_NONE = 3'd0;
  localparam logic [2:0] PRIO_BR   = 3'd1;
  localparam logic [2:0] PRIO_JI   = 3'd2;
  localparam logic [2:0] PRIO_JR   = 3'd3;
  localparam logic [2:0] PRIO_ERET = 3'd4;
  localparam logic [2:0] PRIO_EXC  = 3'd5;

  logic [2:0]  reqPrio_s;
  logic [31:0] reqTarget_s;
  logic [31:0] branchTarget_s;
  logic [31:0] jumpImmTarget_s;

  logic [2:0]  pendPrio_r;
  logic [31:0] pendTarget_r;

  logic [31:0] pcNext_s;
  logic        pendValidNext_s;
  logic [2:0]  pendPrioNext_s;
  logic [31:0] pendTargetNext_s;
  logic        redirSel_s;
  logic [31:0] redirTarget_s;

`ifdef PC_ALIGN_CHECK_EN
  logic        addrErrNext_s;
  logic [31:0] badVAddrNext_s;
`endif

  assign pc4             = pc + STEP_L;
  assign branchTarget_s  = pc4 + {branchImmEx[29:0], 2'b00};
  assign jumpImmTarget_s = {pc4[31:28], jumpImm, 2'b00};

  // Pick the highest-priority request raised this cycle and its target.
  always_comb begin
    reqPrio_s   = PRIO_NONE;
    reqTarget_s = 32'h0000_0000;
    if (takeException) begin
      reqPrio_s   = PRIO_EXC;
      reqTarget_s = EXC_VECTOR;
    end else if (takeEret) begin
      reqPrio_s   = PRIO_ERET;
      reqTarget_s = epc;
    end else if (takeJumpReg) begin
      reqPrio_s   = PRIO_JR;
      reqTarget_s = jumpReg;
    end else if (takeJumpImm) begin
      reqPrio_s   = PRIO_JI;
      reqTarget_s = jumpImmTarget_s;
    end else if (takeBranch) begin
      reqPrio_s   = PRIO_BR;
      reqTarget_s = branchTarget_s;
    end else begin
      reqPrio_s   = PRIO_NONE;
      reqTarget_s = 32'h0000_0000;
    end
  end

  // Next PC and pending-redirect bookkeeping.
  always_comb begin
    pcNext_s         = pc;
    pendValidNext_s  = redirectPending;
    pendPrioNext_s   = pendPrio_r;
    pendTargetNext_s = pendTarget_r;
    redirSel_s       = 1'b0;
    redirTarget_s    = 32'h0000_0000;
`ifdef PC_ALIGN_CHECK_EN
    addrErrNext_s    = 1'b0;
    badVAddrNext_s   = badVAddr;
`endif
    if (takeException) begin
      // Exceptions redirect immediately, even through a stall.
      pcNext_s         = EXC_VECTOR;
      pendValidNext_s  = 1'b0;
      pendPrioNext_s   = PRIO_NONE;
      pendTargetNext_s = 32'h0000_0000;
    end else if (stall) begin
      // Hold the PC; remember the request unless a stronger one is pending.
      if ((reqPrio_s != PRIO_NONE) &&
          (!redirectPending || (reqPrio_s >= pendPrio_r))) begin
        pendValidNext_s  = 1'b1;
        pendPrioNext_s   = reqPrio_s;
        pendTargetNext_s = reqTarget_s;
      end else begin
        pendValidNext_s  = redirectPending;
      end
    end else begin
      // Unstalled: a fresh request beats the pending one; pending is consumed.
      pendValidNext_s  = 1'b0;
      pendPrioNext_s   = PRIO_NONE;
      pendTargetNext_s = 32'h0000_0000;
      if (reqPrio_s != PRIO_NONE) begin
        redirSel_s    = 1'b1;
        redirTarget_s = reqTarget_s;
      end else if (redirectPending) begin
        redirSel_s    = 1'b1;
        redirTarget_s = pendTarget_r;
      end else begin
        pcNext_s      = pc4;
      end
    end

    if (redirSel_s) begin
`ifdef PC_ALIGN_CHECK_EN
      if (redirTarget_s[1:0] != 2'b00) begin
        pcNext_s       = EXC_VECTOR;
        addrErrNext_s  = 1'b1;
        badVAddrNext_s = redirTarget_s;
      end else begin
        pcNext_s       = redirTarget_s;
      end
`else
      pcNext_s = redirTarget_s;
`endif
    end else begin
      redirTarget_s = redirTarget_s;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc              <= RESET_VECTOR;
      redirectPending <= 1'b0;
      pendPrio_r      <= PRIO_NONE;
      pendTarget_r    <= 32'h0000_0000;
`ifdef PC_ALIGN_CHECK_EN
      addrErr         <= 1'b0;
      badVAddr        <= 32'h0000_0000;
`endif
    end else begin
      pc              <= pcNext_s;
      redirectPending <= pendValidNext_s;
      pendPrio_r      <= pendPrioNext_s;
      pendTarget_r    <= pendTargetNext_s;
`ifdef PC_ALIGN_CHECK_EN
      addrErr         <= addrErrNext_s;
      badVAddr        <= badVAddrNext_s;
`endif
    end
  end

endmodule
